// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath sequencing blocks: FSM state
// encodings and count-direction mode constants.
package rsa_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam bit DIR_DOWN = 1'b0;
   localparam bit DIR_UP   = 1'b1;

endpackage

// File: rtl/bit_iter_counter.sv
// Iteration counter for bit-serial loops (e.g. exponent scan) with a start/busy/done
// handshake. Define BIT_ITER_ABORT_EN to add the abort input.
module bit_iter_counter
   import rsa_pkg::*;
#(
   parameter int WIDTH = 6,
   parameter bit DIR   = DIR_DOWN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] in,
   input  logic             step,
`ifdef BIT_ITER_ABORT_EN
   input  logic             abort,
`endif
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             last,
   output logic             done
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] term_q,  term_d;
   logic             at_term;

   assign at_term = (count_q == term_q);

   always_comb begin
      // NOTE: every _d gets a hold default first so no path through the case infers a latch.
      state_d = state_q;
      count_d = count_q;
      term_d  = term_q;
      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               state_d = RUN;
               count_d = (DIR == DIR_UP) ? '0 : in;
               term_d  = (DIR == DIR_UP) ? in : '0;
            end
         end
         RUN: begin
`ifdef BIT_ITER_ABORT_EN
            if (abort) begin
               state_d = IDLE;
               count_d = '0;
            end else
`endif
            if (step) begin
               if (at_term) state_d = DONE;
               else count_d = (DIR == DIR_UP) ? count_q + ONE : count_q - ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         term_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         term_q  <= term_d;
      end
   end

   // Outputs decode registered state only; no input reaches an output combinationally.
   assign count = count_q;
   assign busy  = (state_q == RUN);
   assign last  = (state_q == RUN) && at_term;
   assign done  = (state_q == DONE);

endmodule

// File: doc/bit_iter_counter.md
# bit_iter_counter

Parametrised iteration counter that sequences bit-serial loops in the RSA datapath, such as the square-and-multiply exponent scan. It is the successor of the fixed 6-bit preset down counter. It adds:
- a width parameter and a count-direction mode,
- a start/busy/done handshake,
- a per-iteration step strobe from the datapath,
- a live count output used as the exponent bit index.

## Interface
Parameters:
- WIDTH, 6, width of load value and count.
- DIR, 0, 0 = count down from in to 0; 1 = count up from 0 to in.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
- start  input  1  load request; accepted only in IDLE or DONE.
- in  input  WIDTH  iteration bound, sampled when start is accepted.
- step  input  1  advance strobe; the datapath finished the iteration at the current count.
- count  output  WIDTH  current index (bit index for the exponent scan).
- busy  output  1  high while in RUN.
- last  output  1  busy and count equals terminal value; the current iteration is the final one.
- done  output  1  one-cycle pulse after the final step.
- abort  input  1  only present with BIT_ITER_ABORT_EN.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 loads the counter. DIR=0: count<=in, terminal<=0. DIR=1: count<=0, terminal<=in.
  - Next state RUN.
  - step is ignored in IDLE.
- RUN:
  - step=1 with count!=terminal: count decrements (DIR=0) or increments (DIR=1).
  - step=1 with count==terminal: next state DONE, count held.
  - step=0: hold.
  - start is ignored in RUN.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - Next state IDLE; if start=1 in this cycle, load as in IDLE and go straight to RUN.
- Every load performs in+1 iterations, one per accepted step. in=0 gives exactly one iteration.
- Arithmetic is modulo 2^WIDTH. Wrap cannot occur, because movement stops at the terminal value.
- No combinational path from any input to any output. last is decoded from registered state only.
- Reset values (rst_n=0 at a clock edge): state=IDLE, count=0, terminal=0, busy=0, last=0, done=0.
- rst_n has priority over all other inputs, including in mid-RUN and in DONE; no done pulse is emitted.

## Timing
- start accepted at edge T0: busy=1 and count valid from T0 (outputs after that edge).
- With step held high every cycle, the counter advances once per edge. The final step is taken at edge T0+in+1, done=1 for the cycle following it, and busy=0 in the same cycle.
- Start-to-done latency is in+1 cycles plus the sum of any step-idle cycles.
- last is high in the cycle where the final accepted step occurs.
- start+step in the same IDLE cycle: start only, no advance.
- Back-to-back jobs: start asserted during the done cycle gives zero idle cycles between jobs.

## Configuration
- BIT_ITER_ABORT_EN defined:
  - Adds the abort input.
  - abort=1 in RUN forces IDLE at the next edge, count<=0, busy=0, and no done pulse.
  - abort has priority over step.
  - abort is ignored in IDLE and DONE.
- Not defined: no abort port. Once started, a RUN ends only through the final step or rst_n.

## Structure
- Shared package rsa_pkg holds:
  - state encodings: IDLE=2'b00, RUN=2'b01, DONE=2'b10,
  - DIR mode constants DIR_DOWN=0 and DIR_UP=1.
- Single module with one state register and one count/terminal register set. No sub-module is warranted.
- The terminal comparator is a single equality compare and stays inline.

## Test plan
- WIDTH=6, DIR=0: reset, start with in=5, step high continuously. Response:
  - count sequence 5,4,3,2,1,0,
  - last high only while count=0,
  - done one cycle after the final step, busy low in the done cycle.
- DIR=1, in=3, step pulsed every third cycle. Response:
  - count 0,1,2,3 changes only on step cycles,
  - done after the fourth step, total latency matches the step count.
- in=0: start then one step. Response: last high immediately, done after the single step, count stays 0.
- start during RUN with in=9 while counting from 5: ignored, sequence unaffected. Then start with in=2 in the done cycle: RUN resumes with no IDLE cycle and count=2.
- rst_n low mid-RUN at count=3: next cycle count=0, busy=0, last=0, no done pulse; step afterwards has no effect.
- With BIT_ITER_ABORT_EN: abort and step together at count=4. Response: IDLE, count=0, no done. abort in IDLE has no effect.
